// File: rtl/arm_pkg.sv
// Shared constants and types for the ARMSIM register file and its write decoder.
package arm_pkg;

  localparam int WORD_W         = 32;
  localparam logic [3:0] REG_PC = 4'd15;
  localparam int PC_STEP        = 4;
  localparam int PC_READ_OFFSET = 8;

  typedef logic [3:0]        reg_addr_t;
  typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/decoder_4x16.sv
// Turns the write address and write enable into sixteen one-hot write strobes.
module decoder_4x16
  import arm_pkg::*;
(
  input  logic      we,
  input  reg_addr_t wa,
  output logic [15:0] strb
);

  always_comb begin
    strb = '0;
    if (we) strb[wa] = 1'b1;
  end

endmodule

// File: rtl/arm_register_file.sv
// Sixteen-entry ARM register file: R0-R14 in an array, R15 as a dedicated PC.
// Three combinational read ports; R15 reads return PC+8.
module arm_register_file
  import arm_pkg::*;
#(
  parameter int          WIDTH    = 32,
  parameter logic [WIDTH-1:0] PC_RESET = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  reg_addr_t        wa,
  input  logic [WIDTH-1:0] wd,
  input  reg_addr_t        ra,
  input  reg_addr_t        rb,
  input  reg_addr_t        rc,
  output logic [WIDTH-1:0] qa,
  output logic [WIDTH-1:0] qb,
  output logic [WIDTH-1:0] qc,
  input  logic             pc_en,
  input  logic             pc_ld,
  input  logic [WIDTH-1:0] pc_in,
  output logic [WIDTH-1:0] pc
);

  logic [WIDTH-1:0] regs_q [15];
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_d;
  logic [15:0]      strb;
  logic [WIDTH-1:0] rd_vec [16];

  decoder_4x16 u_dec (
    .we   (we),
    .wa   (wa),
    .strb (strb)
  );

  // Strobe 15 never touches the array; it feeds the PC priority chain below pc_ld.
  always_comb begin
    pc_d = pc_q;
    if (pc_ld)         pc_d = pc_in;
    else if (strb[15]) pc_d = wd;
    else if (pc_en)    pc_d = pc_q + WIDTH'(PC_STEP);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 15; i++) regs_q[i] <= '0;
      pc_q <= PC_RESET;
    end else begin
      for (int i = 0; i < 15; i++)
        if (strb[i]) regs_q[i] <= wd;
      pc_q <= pc_d;
    end
  end

  always_comb begin
    for (int i = 0; i < 15; i++) rd_vec[i] = regs_q[i];
    rd_vec[15] = pc_q + WIDTH'(PC_READ_OFFSET);
  end

  assign qa = rd_vec[ra];
  assign qb = rd_vec[rb];
  assign qc = rd_vec[rc];
  assign pc = pc_q;

endmodule

// File: tb/tb_arm_register_file.sv
// Directed bench for arm_register_file: expectations queued at stimulus time, popped at observation.
module tb_arm_register_file;
  import arm_pkg::*;

  logic        clk = 1'b0;
  logic        reset, we, pc_en, pc_ld;
  reg_addr_t   wa, ra, rb, rc;
  logic [31:0] wd, pc_in, qa, qb, qc, pc;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  arm_register_file #(.WIDTH(32), .PC_RESET(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd),
    .ra(ra), .rb(rb), .rc(rc), .qa(qa), .qb(qb), .qc(qc),
    .pc_en(pc_en), .pc_ld(pc_ld), .pc_in(pc_in), .pc(pc)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $error("FAIL scoreboard_empty observed=%h expected=none", obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e.val) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic idle();
    reset = 1'b0; we = 1'b0; wa = '0; wd = '0;
    pc_en = 1'b0; pc_ld = 1'b0; pc_in = '0;
  endtask

  initial begin
    // Reset with junk on every input
    reset = 1'b1; we = 1'b1; wa = 4'd3; wd = 32'hDEAD_BEEF;
    pc_en = 1'b1; pc_ld = 1'b1; pc_in = 32'h1234_5678;
    ra = 4'd3; rb = 4'd15; rc = 4'd0;
    tick();
    idle();
    #1;
    push("reset_pc", 32'h0);  chk(pc);
    push("reset_r3", 32'h0);  chk(qa);
    push("reset_r15", 32'h8); chk(qb);

    // Write R1, with no bypass during the write cycle
    we = 1'b1; wa = 4'd1; wd = 32'hFFFF_FFFF; ra = 4'd1;
    #1;
    push("no_bypass_r1", 32'h0); chk(qa);
    tick();
    we = 1'b1; wa = 4'd2; wd = 32'hFFFF_0000;
    tick();
    idle();
    ra = 4'd1; rb = 4'd2; rc = 4'd0;
    #1;
    push("read_r1", 32'hFFFF_FFFF); chk(qa);
    push("read_r2", 32'hFFFF_0000); chk(qb);
    push("read_r0", 32'h0);         chk(qc);
    push("pc_idle", 32'h0);         chk(pc);

    // PC advance
    pc_en = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    pc_en = 1'b0; rb = 4'd15;
    #1;
    push("pc_adv3", 32'hC);   chk(pc);
    push("r15_adv3", 32'h14); chk(qb);

    // PC load and wrap
    pc_ld = 1'b1; pc_in = 32'hFFFF_FFFC;
    tick();
    pc_ld = 1'b0;
    push("pc_ld_top", 32'hFFFF_FFFC); chk(pc);
    push("r15_wrap", 32'h4);          chk(qb);
    pc_en = 1'b1;
    tick();
    pc_en = 1'b0;
    push("pc_wrap", 32'h0); chk(pc);

    // Priority: pc_ld beats we to R15 beats pc_en
    pc_ld = 1'b1; pc_in = 32'h100; we = 1'b1; wa = 4'd15; wd = 32'h200; pc_en = 1'b1;
    tick();
    idle();
    push("prio_ld", 32'h100); chk(pc);
    we = 1'b1; wa = 4'd15; wd = 32'h200;
    tick();
    idle();
    push("we_r15", 32'h200); chk(pc);
    we = 1'b1; wa = 4'd15; wd = 32'h300; pc_en = 1'b1;
    tick();
    idle();
    push("we_r15_over_en", 32'h300); chk(pc);

    // Unaligned load is taken verbatim
    pc_ld = 1'b1; pc_in = 32'h0000_0013;
    tick();
    idle();
    push("pc_unaligned", 32'h13); chk(pc);

    // Write R5 with pc_en in the same edge
    we = 1'b1; wa = 4'd5; wd = 32'h0000_FFFF; pc_en = 1'b1;
    tick();
    idle();
    ra = 4'd5; rb = 4'd5; rc = 4'd14;
    #1;
    push("sim_r5", 32'h0000_FFFF); chk(qa);
    push("sim_r5_b", 32'h0000_FFFF); chk(qb);
    push("sim_pc", 32'h17);          chk(pc);

    // Write R14 with pc_ld in the same edge
    we = 1'b1; wa = 4'd14; wd = 32'hA5A5_5A5A; pc_ld = 1'b1; pc_in = 32'h40;
    tick();
    idle();
    push("sim_r14", 32'hA5A5_5A5A); chk(qc);
    push("sim_pc_ld", 32'h40);      chk(pc);

    // Mid-operation reset drops the concurrent write
    reset = 1'b1; we = 1'b1; wa = 4'd7; wd = 32'h9999_9999; pc_en = 1'b1;
    tick();
    idle();
    ra = 4'd7; rb = 4'd15; rc = 4'd14;
    #1;
    push("mid_reset_r7", 32'h0); chk(qa);
    push("mid_reset_r15", 32'h8); chk(qb);
    push("mid_reset_r14", 32'h0); chk(qc);
    push("mid_reset_pc", 32'h0);  chk(pc);
    ra = 4'd1; rb = 4'd2; rc = 4'd5;
    #1;
    push("mid_reset_r1", 32'h0); chk(qa);
    push("mid_reset_r2", 32'h0); chk(qb);
    push("mid_reset_r5", 32'h0); chk(qc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
